// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial two's-complement adder/subtractor.
// Each RUN cycle adds DIGIT bits of the two operand shift registers.
// After N = WIDTH/DIGIT cycles it publishes the result with carry,
// overflow and zero flags. Subtraction is done as A + ~B + 1.
// Accumulate ops take the held result as the A operand.
module addsub_serial #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] sa_r;
   logic [WIDTH-1:0] sb_r;
   logic [WIDTH-1:0] sum_r;
   logic             carry_r;
   logic [CW-1:0]    cnt_r;

   logic [DIGIT-1:0]       dig_sum_s;
   logic                   dig_cout_s;
   logic                   dig_cmsb_s;
   logic [WIDTH+DIGIT-1:0] sum_cat_s;
   logic [WIDTH-1:0]       sum_next_s;
   logic                   last_s;

   // Ripple-add one digit.
   // Returns {carry out, carry into the digit's top bit, sum bits}.
   function automatic logic [DIGIT+1:0] digit_add(
      input logic [DIGIT-1:0] x,
      input logic [DIGIT-1:0] y,
      input logic             cin
   );
      logic [DIGIT-1:0] s;
      logic             c;
      logic             cm;
      s  = {DIGIT{1'b0}};
      c  = cin;
      cm = cin;
      for (int i = 0; i < DIGIT; i++) begin
         cm   = c;
         s[i] = x[i] ^ y[i] ^ c;
         c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      end
      return {c, cm, s};
   endfunction

   // Digit adder datapath.
   // The new sum digit enters the top of the sum register.
   always_comb begin
      {dig_cout_s, dig_cmsb_s, dig_sum_s} =
         digit_add(sa_r[DIGIT-1:0], sb_r[DIGIT-1:0], carry_r);
      sum_cat_s  = {dig_sum_s, sum_r};
      sum_next_s = sum_cat_s[WIDTH+DIGIT-1:DIGIT];
      last_s     = (cnt_r == CW'(N - 1));
   end

   // Control FSM, operand shift registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         sa_r    <= {WIDTH{1'b0}};
         sb_r    <= {WIDTH{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CW{1'b0}};
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= {WIDTH{1'b0}};
         cout    <= 1'b0;
         ovf     <= 1'b0;
         zero    <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  sa_r    <= op[1] ? result : a;
                  sb_r    <= op[0] ? ~b : b;
                  carry_r <= op[0];
                  sum_r   <= {WIDTH{1'b0}};
                  cnt_r   <= {CW{1'b0}};
                  busy    <= 1'b1;
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_RUN: begin
               sa_r    <= sa_r >> DIGIT;
               sb_r    <= sb_r >> DIGIT;
               carry_r <= dig_cout_s;
               sum_r   <= sum_next_s;
               cnt_r   <= cnt_r + CW'(1);
               if (last_s) begin
                  // Publish on the edge that enters DONE.
                  result  <= sum_next_s;
                  cout    <= dig_cout_s;
                  ovf     <= dig_cmsb_s ^ dig_cout_s;
                  zero    <= (sum_next_s == {WIDTH{1'b0}});
                  done    <= 1'b1;
                  busy    <= 1'b0;
                  state_r <= ST_DONE;
               end else begin
                  state_r <= ST_RUN;
               end
            end
            ST_DONE: begin
               done    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               done    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_addsub_serial.sv
// Testbench for addsub_serial.
// Two instances are built, one with DIGIT=1 and one with DIGIT=4.
// sel chooses which instance receives start and which one is observed.
module tb_addsub_serial;

   typedef struct packed {
      logic [7:0] res;
      logic       c;
      logic       v;
      logic       z;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       sel;
   logic [1:0] op;
   logic [7:0] a;
   logic [7:0] b;

   logic       busy1, done1, cout1, ovf1, zero1;
   logic [7:0] result1;
   logic       busy4, done4, cout4, ovf4, zero4;
   logic [7:0] result4;

   logic       busy_m, done_m, cout_m, ovf_m, zero_m;
   logic [7:0] result_m;

   int   checks = 0;
   int   errors = 0;
   logic [7:0] acc [2];
   exp_t sb_q[$];

   always #5 clk = ~clk;

   addsub_serial #(.WIDTH(8), .DIGIT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start & ~sel), .op(op), .a(a), .b(b),
      .busy(busy1), .done(done1), .result(result1),
      .cout(cout1), .ovf(ovf1), .zero(zero1));

   addsub_serial #(.WIDTH(8), .DIGIT(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start & sel), .op(op), .a(a), .b(b),
      .busy(busy4), .done(done4), .result(result4),
      .cout(cout4), .ovf(ovf4), .zero(zero4));

   assign busy_m   = sel ? busy4   : busy1;
   assign done_m   = sel ? done4   : done1;
   assign result_m = sel ? result4 : result1;
   assign cout_m   = sel ? cout4   : cout1;
   assign ovf_m    = sel ? ovf4    : ovf1;
   assign zero_m   = sel ? zero4   : zero1;

   // Reference model: a plain 8-bit add of x and y plus the carry-in.
   // The carry into bit 7 is taken from a separate 7-bit add.
   function automatic exp_t ref_calc(input logic [1:0] o, input logic [7:0] xa,
                                     input logic [7:0] yb, input logic [7:0] r);
      logic [7:0] x, y;
      logic [8:0] full;
      logic [7:0] low;
      exp_t e;
      x    = o[1] ? r : xa;
      y    = o[0] ? ~yb : yb;
      full = {1'b0, x} + {1'b0, y} + {8'd0, o[0]};
      low  = {1'b0, x[6:0]} + {1'b0, y[6:0]} + {7'd0, o[0]};
      e.res = full[7:0];
      e.c   = full[8];
      e.v   = low[7] ^ full[8];
      e.z   = (full[7:0] == 8'd0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outs_zero(input string tag);
      chk({tag, "_busy"}, {31'd0, busy_m}, 32'd0);
      chk({tag, "_done"}, {31'd0, done_m}, 32'd0);
      chk({tag, "_result"}, {24'd0, result_m}, 32'd0);
      chk({tag, "_cout"}, {31'd0, cout_m}, 32'd0);
      chk({tag, "_ovf"}, {31'd0, ovf_m}, 32'd0);
      chk({tag, "_zero"}, {31'd0, zero_m}, 32'd0);
   endtask

   // Run one operation on the selected instance.
   // Checks timing and held outputs, then compares against the scoreboard.
   task automatic run_op(input logic [1:0] o, input logic [7:0] xa,
                         input logic [7:0] xb, input bit glitch);
      exp_t e, g;
      int   n;
      bit   seen;
      logic [7:0] held;
      n = sel ? 2 : 8;
      @(negedge clk);
      start = 1'b1; op = o; a = xa; b = xb;
      e = ref_calc(o, xa, xb, acc[sel]);
      sb_q.push_back(e);
      held = result_m;
      acc[sel] = e.res;
      @(posedge clk); #1;
      start = 1'b0; op = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
      chk("busy_t0", {31'd0, busy_m}, 32'd1);
      seen = 1'b0;
      for (int k = 1; k <= n + 4 && !seen; k++) begin
         if (glitch && k == 3) begin
            start = 1'b1; op = 2'($urandom); a = 8'($urandom); b = 8'($urandom);
         end
         @(posedge clk); #1;
         if (glitch && k == 3) start = 1'b0;
         if (done_m) begin
            seen = 1'b1;
            chk("latency", k, n);
            g = sb_q.pop_front();
            chk("result", {24'd0, result_m}, {24'd0, g.res});
            chk("cout", {31'd0, cout_m}, {31'd0, g.c});
            chk("ovf", {31'd0, ovf_m}, {31'd0, g.v});
            chk("zero", {31'd0, zero_m}, {31'd0, g.z});
            chk("busy_done", {31'd0, busy_m}, 32'd0);
         end else begin
            chk("busy_run", {31'd0, busy_m}, 32'd1);
            chk("result_held", {24'd0, result_m}, {24'd0, held});
         end
      end
      if (!seen) begin
         chk("done_timeout", 32'd0, 32'd1);
         g = sb_q.pop_front();
      end
      @(posedge clk); #1;
      chk("done_width", {31'd0, done_m}, 32'd0);
   endtask

   // Directed add, subtract, overflow and accumulate cases on the selected instance.
   task automatic basic_scenarios();
      run_op(2'b00, 8'h3A, 8'h45, 1'b0);
      chk("add_res", {24'd0, result_m}, 32'h7F);
      chk("add_flags", {29'd0, cout_m, ovf_m, zero_m}, 32'd0);
      run_op(2'b01, 8'h05, 8'h07, 1'b0);
      chk("sub_res", {24'd0, result_m}, 32'hFE);
      chk("sub_flags", {29'd0, cout_m, ovf_m, zero_m}, 32'd0);
      run_op(2'b01, 8'h07, 8'h07, 1'b0);
      chk("subz_res", {24'd0, result_m}, 32'h00);
      chk("subz_flags", {29'd0, cout_m, ovf_m, zero_m}, 32'b101);
      run_op(2'b00, 8'h7F, 8'h01, 1'b0);
      chk("ovf_add_res", {24'd0, result_m}, 32'h80);
      chk("ovf_add_flags", {29'd0, cout_m, ovf_m, zero_m}, 32'b010);
      run_op(2'b01, 8'h80, 8'h01, 1'b0);
      chk("ovf_sub_res", {24'd0, result_m}, 32'h7F);
      chk("ovf_sub_flags", {29'd0, cout_m, ovf_m, zero_m}, 32'b110);
      run_op(2'b00, 8'h10, 8'h20, 1'b0);
      chk("acc0_res", {24'd0, result_m}, 32'h30);
      run_op(2'b10, 8'($urandom), 8'h05, 1'b0);
      chk("acc1_res", {24'd0, result_m}, 32'h35);
      run_op(2'b11, 8'($urandom), 8'h40, 1'b0);
      chk("acc2_res", {24'd0, result_m}, 32'hF5);
      chk("acc2_cout", {31'd0, cout_m}, 32'd0);
   endtask

   // Watchdog so the run always ends.
   initial begin
      #600000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   // Directed sequence followed by a random comparison run.
   initial begin
      rst_n = 1'b0; start = 1'b0; sel = 1'b0; op = 2'b00; a = 8'h00; b = 8'h00;
      acc[0] = 8'h00; acc[1] = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk_outs_zero("rst1");
      sel = 1'b1; #1;
      chk_outs_zero("rst4");
      sel = 1'b0;
      @(negedge clk); rst_n = 1'b1;

      // Accumulate straight after reset starts from a result of 0.
      run_op(2'b10, 8'hAA, 8'h05, 1'b0);
      chk("acc_after_rst", {24'd0, result_m}, 32'h05);

      basic_scenarios();

      // A start pulse while the operation is running must be ignored.
      run_op(2'b00, 8'h21, 8'h13, 1'b1);
      chk("glitch_res", {24'd0, result_m}, 32'h34);
      @(posedge clk); #1;
      chk("glitch_no_op", {31'd0, busy_m}, 32'd0);

      // Reset asserted in the middle of RUN aborts the operation.
      @(negedge clk);
      start = 1'b1; op = 2'b00; a = 8'h11; b = 8'h22;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #2; rst_n = 1'b0;
      #1;
      chk_outs_zero("async_rst");
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         chk("rst_no_done", {31'd0, done_m}, 32'd0);
      end
      @(negedge clk); rst_n = 1'b1;
      acc[0] = 8'h00; acc[1] = 8'h00;
      run_op(2'b00, 8'h3A, 8'h45, 1'b0);
      chk("post_rst_res", {24'd0, result_m}, 32'h7F);

      // Same directed cases on the DIGIT=4 instance, then a random comparison.
      sel = 1'b1;
      basic_scenarios();
      for (int i = 0; i < 1000; i++) begin
         run_op(2'($urandom), 8'($urandom), 8'($urandom), 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
